// File: rtl/uart_mmio_buffer.sv
// rtl/uart_mmio_buffer.sv - RX/TX byte FIFOs between the UART serial core and the MMIO control path
// Both FIFOs are first-word-fall-through; every output depends only on registered pointers and storage.
module uart_mmio_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    core_rx_data,
  input  logic          core_rx_strobe,
  output logic [7:0]    core_tx_data,
  output logic          core_tx_valid,
  input  logic          core_tx_ready,
  output logic [7:0]    UARTDataOut,
  output logic          DataOutValid,
  input  logic          DataOutReady,
  input  logic [7:0]    UARTDataIn,
  input  logic          DataInValid,
  output logic          DataInReady,
  output logic          rx_overrun,
  input  logic          clr_overrun,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count
);

  logic [AW:0] rxWr, rxRd, txWr, txRd;
  logic [7:0]  rxMem [DEPTH];
  logic [7:0]  txMem [DEPTH];

  logic rxEmpty, rxFull, txEmpty, txFull;
  logic rxPush, rxPop, txPush, txPop;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[AW] != rxRd[AW]) && (rxWr[AW-1:0] == rxRd[AW-1:0]);
  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[AW] != txRd[AW]) && (txWr[AW-1:0] == txRd[AW-1:0]);

  assign rxPush = core_rx_strobe && !rxFull;
  assign rxPop  = DataOutReady && !rxEmpty;
  assign txPush = DataInValid && !txFull;
  assign txPop  = core_tx_ready && !txEmpty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxWr       <= '0;
      rxRd       <= '0;
      txWr       <= '0;
      txRd       <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rxPush) rxWr <= rxWr + 1'b1;
      if (rxPop)  rxRd <= rxRd + 1'b1;
      if (txPush) txWr <= txWr + 1'b1;
      if (txPop)  txRd <= txRd + 1'b1;
      // A dropped byte wins over a clear arriving in the same cycle.
      if (core_rx_strobe && rxFull) rx_overrun <= 1'b1;
      else if (clr_overrun)         rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWr[AW-1:0]] <= core_rx_data;
    if (txPush) txMem[txWr[AW-1:0]] <= UARTDataIn;
  end

  assign DataOutValid  = !rxEmpty;
  assign UARTDataOut   = rxEmpty ? 8'h00 : rxMem[rxRd[AW-1:0]];
  assign core_tx_valid = !txEmpty;
  assign core_tx_data  = txEmpty ? 8'h00 : txMem[txRd[AW-1:0]];
  assign DataInReady   = !txFull;
  assign rx_count      = rxWr - rxRd;
  assign tx_count      = txWr - txRd;

endmodule

// File: tb/tb_uart_mmio_buffer.sv
// tb/tb_uart_mmio_buffer.sv - scoreboard bench for uart_mmio_buffer
module tb_uart_mmio_buffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] core_rx_data;
  logic       core_rx_strobe;
  logic [7:0] core_tx_data;
  logic       core_tx_valid;
  logic       core_tx_ready;
  logic [7:0] UARTDataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic [7:0] UARTDataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       rx_overrun;
  logic       clr_overrun;
  logic [3:0] rx_count;
  logic [3:0] tx_count;

  int nCompared = 0;
  int nMismatched = 0;
  logic [7:0] rxExp [$];
  logic [7:0] txExp [$];
  logic [7:0] expByte;

  uart_mmio_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_rx_data(core_rx_data), .core_rx_strobe(core_rx_strobe),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .UARTDataOut(UARTDataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .UARTDataIn(UARTDataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .rx_overrun(rx_overrun), .clr_overrun(clr_overrun),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nCompared++; if (DataOutValid !== 1'b0) begin nMismatched++; $display("FAIL reset_rxvalid: got %b expected 0", DataOutValid); end
    nCompared++; if (UARTDataOut !== 8'h00) begin nMismatched++; $display("FAIL reset_rxdata: got %h expected 00", UARTDataOut); end
    nCompared++; if (core_tx_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_txvalid: got %b expected 0", core_tx_valid); end
    nCompared++; if (core_tx_data !== 8'h00) begin nMismatched++; $display("FAIL reset_txdata: got %h expected 00", core_tx_data); end
    nCompared++; if (DataInReady !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b expected 1", DataInReady); end
    nCompared++; if (rx_count !== 4'd0) begin nMismatched++; $display("FAIL reset_rxcount: got %0d expected 0", rx_count); end
    nCompared++; if (tx_count !== 4'd0) begin nMismatched++; $display("FAIL reset_txcount: got %0d expected 0", tx_count); end
    nCompared++; if (rx_overrun !== 1'b0) begin nMismatched++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
  endtask

  task automatic test_rx_basic();
    core_rx_data = 8'hA5; core_rx_strobe = 1'b1; rxExp.push_back(8'hA5);
    tick();
    core_rx_strobe = 1'b0;
    nCompared++; if (DataOutValid !== 1'b1) begin nMismatched++; $display("FAIL rx_basic_valid: got %b expected 1", DataOutValid); end
    nCompared++; if (rx_count !== 4'(rxExp.size())) begin nMismatched++; $display("FAIL rx_basic_count: got %0d expected %0d", rx_count, rxExp.size()); end
    expByte = rxExp.pop_front();
    nCompared++; if (UARTDataOut !== expByte) begin nMismatched++; $display("FAIL rx_basic_data: got %h expected %h", UARTDataOut, expByte); end
    DataOutReady = 1'b1;
    tick();
    DataOutReady = 1'b0;
    nCompared++; if (DataOutValid !== 1'b0) begin nMismatched++; $display("FAIL rx_basic_popvalid: got %b expected 0", DataOutValid); end
    nCompared++; if (UARTDataOut !== 8'h00) begin nMismatched++; $display("FAIL rx_basic_popdata: got %h expected 00", UARTDataOut); end
  endtask

  task automatic test_rx_overrun();
    for (int i = 1; i <= 9; i++) begin
      core_rx_data = 8'(i); core_rx_strobe = 1'b1;
      if (rxExp.size() < 8) rxExp.push_back(8'(i));
      tick();
    end
    core_rx_strobe = 1'b0;
    nCompared++; if (rx_count !== 4'(rxExp.size())) begin nMismatched++; $display("FAIL ovr_count: got %0d expected %0d", rx_count, rxExp.size()); end
    nCompared++; if (rx_overrun !== 1'b1) begin nMismatched++; $display("FAIL ovr_flag: got %b expected 1", rx_overrun); end
    for (int n = 0; n < 12 && rxExp.size() > 0; n++) begin
      expByte = rxExp.pop_front();
      nCompared++; if (DataOutValid !== 1'b1 || UARTDataOut !== expByte) begin nMismatched++; $display("FAIL ovr_pop: got %b/%h expected 1/%h", DataOutValid, UARTDataOut, expByte); end
      DataOutReady = 1'b1;
      tick();
      DataOutReady = 1'b0;
    end
    nCompared++; if (DataOutValid !== 1'b0) begin nMismatched++; $display("FAIL ovr_empty: got %b expected 0", DataOutValid); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    nCompared++; if (rx_overrun !== 1'b0) begin nMismatched++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun); end
  endtask

  task automatic test_tx_fill_drain();
    core_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      UARTDataIn = (i == 8) ? 8'hFF : 8'(8'h10 + i); DataInValid = 1'b1;
      if (txExp.size() < 8) txExp.push_back(UARTDataIn);
      tick();
      if (i == 7) begin
        nCompared++; if (DataInReady !== 1'b0) begin nMismatched++; $display("FAIL tx_full_ready: got %b expected 0", DataInReady); end
      end
    end
    DataInValid = 1'b0;
    nCompared++; if (tx_count !== 4'(txExp.size())) begin nMismatched++; $display("FAIL tx_full_count: got %0d expected %0d", tx_count, txExp.size()); end
    core_tx_ready = 1'b1;
    for (int n = 0; n < 12 && txExp.size() > 0; n++) begin
      expByte = txExp.pop_front();
      nCompared++; if (core_tx_valid !== 1'b1 || core_tx_data !== expByte) begin nMismatched++; $display("FAIL tx_drain: got %b/%h expected 1/%h", core_tx_valid, core_tx_data, expByte); end
      tick();
    end
    core_tx_ready = 1'b0;
    nCompared++; if (core_tx_valid !== 1'b0 || core_tx_data !== 8'h00) begin nMismatched++; $display("FAIL tx_drained: got %b/%h expected 0/00", core_tx_valid, core_tx_data); end
  endtask

  task automatic test_back_to_back();
    core_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      UARTDataIn = 8'(8'h40 + i); DataInValid = 1'b1; txExp.push_back(UARTDataIn);
      tick();
    end
    core_tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expByte = txExp.pop_front();
      nCompared++; if (core_tx_data !== expByte) begin nMismatched++; $display("FAIL wrap_data: got %h expected %h", core_tx_data, expByte); end
      UARTDataIn = 8'(8'h80 + i); txExp.push_back(UARTDataIn);
      tick();
      nCompared++; if (tx_count !== 4'(txExp.size())) begin nMismatched++; $display("FAIL wrap_count: got %0d expected %0d", tx_count, txExp.size()); end
    end
    DataInValid = 1'b0;
    for (int n = 0; n < 6 && txExp.size() > 0; n++) begin
      expByte = txExp.pop_front();
      nCompared++; if (core_tx_data !== expByte) begin nMismatched++; $display("FAIL wrap_tail: got %h expected %h", core_tx_data, expByte); end
      tick();
    end
    core_tx_ready = 1'b0;
    nCompared++; if (core_tx_valid !== 1'b0) begin nMismatched++; $display("FAIL wrap_empty: got %b expected 0", core_tx_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      core_rx_data = 8'(8'h60 + i); core_rx_strobe = 1'b1; rxExp.push_back(core_rx_data);
      UARTDataIn = 8'(8'h70 + i); DataInValid = (i < 2);
      if (i < 2) txExp.push_back(UARTDataIn);
      tick();
    end
    core_rx_strobe = 1'b0; DataInValid = 1'b0;
    nCompared++; if (rx_count !== 4'd5 || tx_count !== 4'd2) begin nMismatched++; $display("FAIL mid_counts: got %0d/%0d expected 5/2", rx_count, tx_count); end
    #2 reset_n = 1'b0;
    #1;
    rxExp.delete(); txExp.delete();
    nCompared++; if (DataOutValid !== 1'b0 || UARTDataOut !== 8'h00 || rx_count !== 4'd0) begin nMismatched++; $display("FAIL mid_rx: got %b/%h/%0d expected 0/00/0", DataOutValid, UARTDataOut, rx_count); end
    nCompared++; if (core_tx_valid !== 1'b0 || core_tx_data !== 8'h00 || tx_count !== 4'd0 || DataInReady !== 1'b1) begin nMismatched++; $display("FAIL mid_tx: got %b/%h/%0d/%b expected 0/00/0/1", core_tx_valid, core_tx_data, tx_count, DataInReady); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    core_rx_data = 8'h3C; core_rx_strobe = 1'b1; rxExp.push_back(8'h3C);
    tick();
    core_rx_strobe = 1'b0;
    expByte = rxExp.pop_front();
    nCompared++; if (DataOutValid !== 1'b1 || UARTDataOut !== expByte || rx_count !== 4'd1) begin nMismatched++; $display("FAIL mid_first: got %b/%h/%0d expected 1/%h/1", DataOutValid, UARTDataOut, rx_count, expByte); end
    DataOutReady = 1'b1;
    tick();
    DataOutReady = 1'b0;
  endtask

  task automatic test_overrun_precedence();
    for (int i = 0; i < 8; i++) begin
      core_rx_data = 8'(8'hC0 + i); core_rx_strobe = 1'b1; rxExp.push_back(core_rx_data);
      tick();
    end
    nCompared++; if (rx_count !== 4'd8) begin nMismatched++; $display("FAIL prec_full: got %0d expected 8", rx_count); end
    core_rx_data = 8'hEE; DataOutReady = 1'b1; clr_overrun = 1'b1;
    expByte = rxExp.pop_front();
    nCompared++; if (UARTDataOut !== expByte) begin nMismatched++; $display("FAIL prec_head: got %h expected %h", UARTDataOut, expByte); end
    tick();
    core_rx_strobe = 1'b0; DataOutReady = 1'b0; clr_overrun = 1'b0;
    nCompared++; if (rx_overrun !== 1'b1) begin nMismatched++; $display("FAIL prec_flag: got %b expected 1", rx_overrun); end
    nCompared++; if (rx_count !== 4'(rxExp.size())) begin nMismatched++; $display("FAIL prec_count: got %0d expected %0d", rx_count, rxExp.size()); end
    for (int n = 0; n < 10 && rxExp.size() > 0; n++) begin
      expByte = rxExp.pop_front();
      nCompared++; if (DataOutValid !== 1'b1 || UARTDataOut !== expByte) begin nMismatched++; $display("FAIL prec_drain: got %b/%h expected 1/%h", DataOutValid, UARTDataOut, expByte); end
      DataOutReady = 1'b1;
      tick();
      DataOutReady = 1'b0;
    end
    nCompared++; if (DataOutValid !== 1'b0) begin nMismatched++; $display("FAIL prec_empty: got %b expected 0", DataOutValid); end
  endtask

  initial begin
    reset_n = 1'b0;
    core_rx_data = 8'h00; core_rx_strobe = 1'b0; core_tx_ready = 1'b0;
    DataOutReady = 1'b0; UARTDataIn = 8'h00; DataInValid = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_rx_basic();
    test_rx_overrun();
    test_tx_fill_drain();
    test_back_to_back();
    test_reset_mid();
    test_overrun_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/uart_mmio_buffer.md
# uart_mmio_buffer

Byte-buffering stage between the UART serial core and the processor's memory-mapped UART control path. It holds received bytes in an RX FIFO until the memory stage pops them, and holds bytes written by store instructions in a TX FIFO until the serial transmitter accepts them. Its CPU-side handshake signals (`DataOutValid`, `UARTDataOut`, `DataInReady`) are exactly the inputs consumed by the UART control logic in the control unit, and it consumes that logic's `DataOutReady` / `DataInValid` strobes.

## Interface
- `DEPTH`, 8, entries per FIFO; power of two, at least 2
- `AW`, 3, log2(`DEPTH`)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `core_rx_data`  in  8  byte from the serial receiver
- `core_rx_strobe`  in  1  one-cycle pulse: `core_rx_data` valid
- `core_tx_data`  out  8  head of TX FIFO
- `core_tx_valid`  out  1  TX FIFO non-empty
- `core_tx_ready`  in  1  transmitter accepts `core_tx_data` this cycle
- `UARTDataOut`  out  8  head of RX FIFO
- `DataOutValid`  out  1  RX FIFO non-empty
- `DataOutReady`  in  1  CPU pops RX head this cycle
- `UARTDataIn`  in  8  byte from store instruction (low byte of store data)
- `DataInValid`  in  1  CPU pushes `UARTDataIn` this cycle
- `DataInReady`  out  1  TX FIFO not full
- `rx_overrun`  out  1  sticky: a received byte was dropped
- `clr_overrun`  in  1  clears `rx_overrun`
- `rx_count`  out  AW+1  RX occupancy, 0..`DEPTH`
- `tx_count`  out  AW+1  TX occupancy, 0..`DEPTH`

## Operation
- Two independent circular FIFOs, each using `AW+1`-bit read/write pointers.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low `AW` bits are equal.
  - Pointers wrap modulo 2·`DEPTH`; count = wr − rd in `AW+1` bits.
- RX push: `core_rx_strobe` while not full writes the byte and advances the write pointer.
  - If the FIFO is full, the byte is dropped, state is unchanged, and `rx_overrun` is set.
  - A strobe that arrives while full is dropped even if `DataOutReady` pops in the same cycle; there is no bypass.
- RX pop: `DataOutReady` while `DataOutValid` advances the read pointer. `DataOutReady` while empty is ignored.
- TX push: `DataInValid` while `DataInReady` writes the byte. `DataInValid` while full is ignored; the byte is lost and no flag is raised.
- TX pop: `core_tx_valid` and `core_tx_ready` together advance the read pointer.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- Simultaneous push and pop on an empty FIFO: only the push occurs, since pop requires valid.
- Both FIFOs are first-word-fall-through: the head is presented on the data output whenever valid is high.
- Data outputs read 8'h00 whenever the corresponding valid is low; storage is never exposed while empty.
- `rx_overrun` behaviour:
  - Set has priority over `clr_overrun` in the same cycle.
  - Otherwise `clr_overrun` clears it.
  - It does not affect FIFO contents.

## Timing
- Reset (`reset_n` low, asynchronous):
  - All pointers go to 0 and `rx_overrun` goes to 0.
  - Outputs: `DataOutValid`=0, `UARTDataOut`=0, `core_tx_valid`=0, `core_tx_data`=0, `DataInReady`=1, `rx_count`=0, `tx_count`=0.
  - Reset asserted mid-operation discards all buffered bytes immediately. No partial transfer completes.
- Release is synchronous to `clk`: the first push can be accepted on the first rising edge with `reset_n` high.
- Push-to-visible latency is 1 cycle: a byte pushed at edge N gives valid=1 and data=byte after edge N.
- Pop takes effect at the edge. The next head, or valid=0, appears after that same edge.
- Valid, ready, data and count outputs are all combinational functions of registered pointers and storage only. There are no combinational paths from any input to any output.
- Throughput: one push and one pop per FIFO per cycle, sustained.
- Full/empty boundaries:
  - With `DEPTH`=8, the 8th push drives `DataInReady` low (or makes the RX FIFO full) after that edge.
  - The first pop from full restores ready after that edge.

## Test plan
- Reset then idle:
  - All outputs are at their reset values.
  - Strobe `core_rx_data`=8'hA5 → after 1 edge, `DataOutValid`=1, `UARTDataOut`=8'hA5, `rx_count`=1.
  - Pulse `DataOutReady` → `DataOutValid`=0, `UARTDataOut`=0.
- RX overrun:
  - Push 9 bytes 8'h01..8'h09 with no pops → `rx_count`=8 and `rx_overrun`=1; 8'h09 is dropped.
  - Pop 8 → data arrives in order 01..08.
  - `clr_overrun` → `rx_overrun`=0.
- TX fill and drain:
  - Hold `core_tx_ready`=0 and push 8'h10..8'h17 → `DataInReady`=0 after the 8th push.
  - A 9th `DataInValid` (8'hFF) is ignored.
  - Raise `core_tx_ready` → 8'h10..8'h17 appear one per cycle, then `core_tx_valid`=0.
- Wrap-around and concurrency:
  - Stream 20 bytes through TX with push and pop in the same cycle from count 3 → count stays 3 and order is preserved across the pointer wrap.
- Reset mid-operation:
  - With `rx_count`=5 and `tx_count`=2, pulse `reset_n` low between edges → outputs go to reset values immediately, without waiting for a clock edge.
  - Push 8'h3C → it is the first byte out.
- Overrun precedence:
  - With RX full, drive `core_rx_strobe`, `DataOutReady` and `clr_overrun` in the same cycle → `rx_overrun`=1, `rx_count`=7, and the strobed byte is absent from the FIFO.
